// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } arbState_t;

  localparam int LATENCY_DEFAULT    = 2;
  localparam int STARVE_MAX_DEFAULT = 3;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one memory port.
// Each transfer holds the port for LATENCY cycles; acks follow one cycle later.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY    = LATENCY_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rest,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_wdata,
  output logic        if_ack,
  output logic [15:0] if_rdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        freeze_if,
  output logic        freeze_pipe
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [2:0]    CNT_LOAD   = 3'(LATENCY - 1);

  arbState_t     state, stateNext;
  logic [2:0]    cnt;
  logic [SW-1:0] starveCnt;
  logic [15:0]   latAddr, latWdata;
  logic          latWrite;
  logic          ifAckQ, dAckQ;
  logic [15:0]   ifRdataQ, dRdataQ;
  logic          ifReqEff, dReqEff, grantIf, grantD, busy, busyDone;

  // A requester being acked this cycle is still holding its line; mask it.
  always_comb begin
    ifReqEff  = if_req & ~ifAckQ;
    dReqEff   = (d_read | d_write) & ~dAckQ;
    busy      = (state != IDLE);
    busyDone  = busy && (cnt == 3'd0);
    grantIf   = 1'b0;
    grantD    = 1'b0;
    stateNext = state;
    case (state)
      IDLE: begin
        if (dReqEff && !(ifReqEff && (starveCnt == STARVE_LIM))) begin
          grantD    = 1'b1;
          stateNext = D_BUSY;
        end else if (ifReqEff) begin
          grantIf   = 1'b1;
          stateNext = IF_BUSY;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (cnt == 3'd0) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rest) state <= IDLE;
    else      state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      cnt       <= 3'd0;
      starveCnt <= '0;
      latAddr   <= 16'h0000;
      latWdata  <= 16'h0000;
      latWrite  <= 1'b0;
      ifAckQ    <= 1'b0;
      dAckQ     <= 1'b0;
      ifRdataQ  <= 16'h0000;
      dRdataQ   <= 16'h0000;
    end else begin
      ifAckQ <= busyDone && (state == IF_BUSY);
      dAckQ  <= busyDone && (state == D_BUSY);

      if (grantIf || grantD) begin
        cnt      <= CNT_LOAD;
        latAddr  <= grantD ? d_addr : if_addr;
        latWdata <= grantD ? d_wdata : 16'h0000;
        latWrite <= grantD & d_write;
      end else if (busy && (cnt != 3'd0)) begin
        cnt <= cnt - 3'd1;
      end

      if (grantIf)
        starveCnt <= '0;
      else if (grantD && ifReqEff && (starveCnt != STARVE_LIM))
        starveCnt <= starveCnt + SW'(1);

      if (busyDone) begin
        if (state == IF_BUSY)  ifRdataQ <= mem_rdata;
        else if (!latWrite)    dRdataQ  <= mem_rdata;
      end
    end
  end

  assign mem_addr    = latAddr;
  assign mem_wdata   = latWdata;
  assign mem_read    = busy & ~latWrite;
  assign mem_write   = busy & latWrite;
  assign if_ack      = ifAckQ;
  assign d_ack       = dAckQ;
  assign if_rdata    = ifRdataQ;
  assign d_rdata     = dRdataQ;
  assign freeze_if   = if_req & ~ifAckQ;
  assign freeze_pipe = (d_read | d_write) & ~dAckQ;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter LATENCY, default 2: memory access cycles per transfer; legal range 1..7.
REQ-002 Parameter STARVE_MAX, default 3: consecutive data grants allowed while a fetch waits.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rest  in  1  reset, synchronous, active-high.
REQ-005 if_req  in  1  instruction fetch request; held high until if_ack.
REQ-006 if_addr  in  16  fetch address (PC value).
REQ-007 d_read  in  1  data read request; held high until d_ack.
REQ-008 d_write  in  1  data write request; held high until d_ack.
REQ-009 d_addr  in  16  data address.
REQ-010 d_wdata  in  16  data write value.
REQ-011 mem_rdata  in  16  read data returned by the unified memory.
REQ-012 mem_addr  out  16  address driven to the memory.
REQ-013 mem_read  out  1  memory read strobe.
REQ-014 mem_write  out  1  memory write strobe.
REQ-015 mem_wdata  out  16  memory write data.
REQ-016 if_ack  out  1  one-cycle pulse; fetch complete; if_rdata valid.
REQ-017 if_rdata  out  16  fetched instruction word, registered.
REQ-018 d_ack  out  1  one-cycle pulse; data access complete.
REQ-019 d_rdata  out  16  data read result, registered.
REQ-020 freeze_if  out  1  PC freeze: if_req high and if_ack low.
REQ-021 freeze_pipe  out  1  MEM-stage stall: (d_read or d_write) high and d_ack low.

Function
REQ-022 FSM states IDLE, IF_BUSY, D_BUSY; arbitration occurs only in IDLE.
REQ-023 In IDLE, a data request wins, unless if_req is high and starve_cnt equals STARVE_MAX, in which case the fetch wins.
REQ-024 With only one request pending in IDLE, that request is granted.
REQ-025 On grant, address, write data and operation are latched, and the state moves to IF_BUSY or D_BUSY on the next edge.
REQ-026 In a BUSY state, mem_addr, mem_read/mem_write and mem_wdata are driven from latched values for exactly LATENCY cycles; in IDLE all memory strobes are 0.
REQ-027 A down-counter loads LATENCY-1 on grant; BUSY ends when it reads 0.
REQ-028 Read completion: at the end of the last BUSY cycle, mem_rdata is captured into if_rdata or d_rdata; the matching ack pulses in the following cycle; the state returns to IDLE.
REQ-029 Write completion: d_ack pulses the same way; d_rdata is unchanged.
REQ-030 Grant-to-ack latency is LATENCY+1 cycles; back-to-back transfers cost LATENCY+1 cycles each.
REQ-031 In the ack cycle, the acked requester's request line is ignored by arbitration; the other requester may be granted in that same cycle.
REQ-032 d_read and d_write both high is treated as a write.
REQ-033 Request changes while BUSY have no effect on the transfer in flight.
REQ-034 starve_cnt increments, saturating at STARVE_MAX, on each data grant made while if_req is high; it clears to 0 on any fetch grant.
REQ-035 freeze_if and freeze_pipe are combinational from the request inputs and the registered acks.

Reset
REQ-036 While rest is high at a clock edge, the next state is IDLE, the counter and starve_cnt are 0, all acks and strobes are 0, and if_rdata and d_rdata are 0x0000.
REQ-037 Reset during a BUSY state abandons the access: no ack is issued, and the strobes drop on the reset edge.
REQ-038 Requests present during reset are arbitrated starting from the first cycle after rest goes low.

Structure
REQ-039 Shared package mem_arb_pkg holds the state enum, the LATENCY default and the STARVE_MAX default.
REQ-040 The block is a single module; no sub-module is warranted.

Verification (LATENCY=2, STARVE_MAX=3)
REQ-041 Fetch-only read: if_req with if_addr=0x0010 and mem_rdata=0x1234 -> mem_read high for 2 cycles with mem_addr=0x0010; if_ack pulses 3 cycles after grant; if_rdata=0x1234; freeze_if high until the ack.
REQ-042 Simultaneous requests: if_req plus d_read at d_addr=0x0200 -> the data access is served first (d_ack), then the fetch is granted in the d_ack cycle; freeze_if stays high throughout.
REQ-043 Write: d_write with d_addr=0x0300 and d_wdata=0xBEEF -> mem_write high for 2 cycles with mem_wdata=0xBEEF; d_ack pulses; d_rdata is unchanged.
REQ-044 Starvation: if_req held while data requests are issued back-to-back -> exactly 3 data grants, then the fetch is granted; starve_cnt returns to 0.
REQ-045 Reset mid-access: rest asserted in the first D_BUSY cycle -> strobes 0 on the next edge, no d_ack, state IDLE; the request is re-served after rest is released.
